dotprod_acc: RTL and testbench
==============================

Name: dotprod_acc

Overview:
- Streaming accumulator directly downstream of the combinational N-lane dot-product stage.
- Consumes one partial dot product per handshake beat; each beat is the result for one N-element chunk of a long vector.
- Sums beats until a beat marked last, then presents the total and the beat count on a valid/ready output.
- Lets a fixed-width dot-product datapath compute dot products of arbitrary-length vectors.

Parameters:
- N, 8, lanes of the upstream dot-product stage; used only to derive IW.
- DW, 16, element width of the upstream stage.
- IW, DW+$clog2(N), input partial-sum width; matches the upstream output width.
- OW, 40, accumulator and output width; must satisfy OW >= IW.
- CW, 16, beat-counter width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- nreset  input  1  synchronous active-low reset.
- in_valid  input  1  partial sum valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  IW  unsigned partial sum from the dot-product stage.
- in_last  input  1  beat is the final chunk of the current vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  OW  accumulated sum.
- out_count  output  CW  number of beats in this result.
- out_ovf  output  1  accumulation exceeded OW bits at some point in this result.

Behaviour:
- Reset: synchronous, sampled only on clk rising edge with nreset=0.
  - Clears acc, count and ovf to 0, state to IDLE, out_valid=0.
  - Takes priority over every other event.
  - Mid-vector reset discards the partial accumulation; no result is emitted.
- Data is unsigned; in_data is zero-extended to OW.
- State IDLE (no beat accepted yet), in_ready=1, out_valid=0:
  - Accept (in_valid & in_ready) without in_last: acc<=in_data, count<=1, ovf<=0, go to ACC.
  - Accept with in_last: acc<=in_data, count<=1, ovf<=0, go to DONE.
- State ACC, in_ready=1, out_valid=0:
  - Accept: acc<=acc+in_data, count<=count+1.
  - Carry out of OW bits sets ovf sticky; acc wraps modulo 2^OW.
  - in_last on the accepted beat goes to DONE; otherwise stays in ACC.
  - in_valid=0: hold all state.
- State DONE: in_ready=0, out_valid=1; out_data=acc, out_count=count, out_ovf=ovf.
  - Outputs stable while out_ready=0.
  - out_valid & out_ready goes to IDLE next cycle.
- Latency:
  - Result is valid the cycle after the last beat is accepted.
  - in_ready is 0 for exactly one cycle when out_ready=1 already in DONE.
  - Throughput: one beat per cycle within a vector; one idle input cycle between vectors.
- in_ready is a function of state only; no combinational path from out_ready or in_valid.
- in_data and in_last are ignored when in_valid=0.
- Count saturates at 2^CW-1 and does not wrap; it does not affect the sum.
- out_data, out_count and out_ovf read 0 outside DONE.

Optional Feature:
- DOTPROD_ACC_SAT_EN defined:
  - On carry out of OW bits, acc clamps to 2^OW-1 and stays clamped for the rest of the vector.
  - out_ovf still reports the overflow.
- DOTPROD_ACC_SAT_EN undefined: modulo-2^OW wrap as described above.

Test Plan:
- Reset then single beat: in_data=100, in_last=1 -> next cycle out_valid=1, out_data=100, out_count=1, out_ovf=0; in_ready=0 until out_ready.
- Four beats 10, 20, 30, 40 back-to-back, last on 40 -> out_data=100, out_count=4; in_ready stays 1 across all four beats.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> outputs stable, no beat accepted; out_ready=1 -> IDLE next cycle, following beat accepted.
- Overflow with OW=IW=19: beats 0x7FFFF and 0x00002 -> without macro out_data=0x00001, out_ovf=1; with DOTPROD_ACC_SAT_EN out_data=0x7FFFF, out_ovf=1.
- Reset mid-vector after beats 5, 6 -> out_valid=0. New vector 7 (last) -> out_data=7, out_count=1.
- Gapped input: beats 1, 2, 3 with in_valid low 2 cycles between each -> out_data=6, out_count=3; no spurious accumulation during gaps.

Source files
------------

// File: rtl/dotprod_acc.sv
// Streaming accumulator for chunked dot products: sums partial sums until in_last,
// then presents total, beat count and overflow flag. Define DOTPROD_ACC_SAT_EN to clamp instead of wrap.
module dotprod_acc #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int IW = DW + $clog2(N),
  parameter int OW = 40,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] acc_p0;
  logic [CW-1:0] count_p0;
  logic          ovf_p0;
  logic          accept;
  logic [OW-1:0] in_ext;
  logic [OW:0]   sum;

  // Returns {carry, result}; the result clamps to all ones on carry when saturation is enabled.
  function automatic logic [OW:0] acc_add(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef DOTPROD_ACC_SAT_EN
    if (s[OW]) s[OW-1:0] = '1;
`endif
    return s;
  endfunction

  function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  assign in_ext = OW'(in_data);
  assign accept = in_valid && in_ready;
  assign sum    = acc_add(acc_p0, in_ext);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    out_count = '0;
    out_ovf   = 1'b0;
    case (state)
      IDLE, ACC: begin
        if (in_valid) state_nxt = in_last ? DONE : ACC;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_data  = acc_p0;
        out_count = count_p0;
        out_ovf   = ovf_p0;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulation stage: first beat of a vector loads, later beats add
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      acc_p0   <= '0;
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (state == IDLE) begin
          acc_p0   <= in_ext;
          count_p0 <= CW'(1);
          ovf_p0   <= 1'b0;
        end else begin
          acc_p0   <= sum[OW-1:0];
          count_p0 <= count_inc(count_p0);
          ovf_p0   <= ovf_p0 | sum[OW];
        end
      end
    end
  end

endmodule

// File: tb/tb_dotprod_acc.sv
// Directed bench for dotprod_acc: main instance with OW=IW=19, second instance with CW=2
// sharing the same stimulus to observe count saturation and a wide accumulator.
module tb_dotprod_acc;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic [18:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [18:0] out_data;
  logic [15:0] out_count;

  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [39:0] out_data_s;
  logic [1:0]  out_count_s;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  dotprod_acc #(.N(8), .DW(16), .OW(19), .CW(16)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
  );

  dotprod_acc #(.N(8), .DW(16), .OW(40), .CW(2)) dut_s (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [18:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [18:0] exp_ovf_data;
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    nreset = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf",   out_ovf,   0);

    // single beat
    beat(19'd100, 1'b1);
    chk("single_valid", out_valid, 1);
    chk("single_data",  out_data,  100);
    chk("single_count", out_count, 1);
    chk("single_ovf",   out_ovf,   0);
    chk("single_ready", in_ready,  0);
    out_ready = 1'b1;
    step();
    chk("single_idle_valid", out_valid, 0);
    chk("single_idle_ready", in_ready,  1);

    // four back-to-back beats
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 19'(10 * i);
      in_last  = (i == 4);
      step();
    end
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data",  out_data,  100);
    chk("b2b_count", out_count, 4);
    drain();

    // backpressure in DONE with in_valid held high
    out_ready = 1'b0;
    beat(19'd5, 1'b1);
    in_valid = 1'b1;
    in_data  = 19'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_data",  out_data,  5);
      chk("bp_count", out_count, 1);
      chk("bp_ready", in_ready,  0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready,  1);
    step();
    in_valid = 1'b0;
    chk("bp_next_data",  out_data,  9);
    chk("bp_next_count", out_count, 1);
    drain();

    // overflow past 19 bits
`ifdef DOTPROD_ACC_SAT_EN
    exp_ovf_data = 19'h7FFFF;
`else
    exp_ovf_data = 19'h00001;
`endif
    beat(19'h7FFFF, 1'b0);
    beat(19'h00002, 1'b1);
    chk("ovf_valid",    out_valid,  1);
    chk("ovf_data",     out_data,   exp_ovf_data);
    chk("ovf_flag",     out_ovf,    1);
    chk("ovf_count",    out_count,  2);
    chk("wide_data",    out_data_s, 40'h80001);
    chk("wide_ovf",     out_ovf_s,  0);
    drain();

    // reset mid-vector
    beat(19'd5, 1'b0);
    beat(19'd6, 1'b0);
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready,  1);
    step();
    chk("midrst_valid2", out_valid, 0);
    beat(19'd7, 1'b1);
    chk("midrst_data",  out_data,  7);
    chk("midrst_count", out_count, 1);
    drain();

    // gapped input; garbage on data/last while in_valid is low
    for (int i = 1; i <= 3; i++) begin
      beat(19'(i), i == 3);
      if (i < 3) begin
        in_data = 19'd55;
        in_last = 1'b1;
        step();
        chk("gap_valid", out_valid, 0);
        step();
        chk("gap_valid", out_valid, 0);
      end
    end
    chk("gap_data",  out_data,  6);
    chk("gap_count", out_count, 3);
    drain();

    // count saturation on the CW=2 instance
    for (int i = 1; i <= 5; i++) beat(19'd1, i == 5);
    chk("csat_count_s", out_count_s, 3);
    chk("csat_data_s",  out_data_s,  5);
    chk("csat_count",   out_count,   5);
    chk("csat_data",    out_data,    5);
    drain();
    chk("end_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
